// File: rtl/ibex_avalon_arb_pkg.sv
// Shared types for the Ibex-to-Avalon arbiter: source ids, response tags,
// arbiter states and Avalon response codes.
package ibex_avalon_arb_pkg;

  typedef enum logic {
    SRC_INSTR = 1'b0,
    SRC_DATA  = 1'b1
  } src_e;

  typedef struct packed {
    src_e src;
    logic is_write;
  } tag_t;

  typedef enum logic {
    ARB  = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

  typedef enum logic [1:0] {
    RESP_OKAY     = 2'b00,
    RESP_RESERVED = 2'b01,
    RESP_SLVERR   = 2'b10,
    RESP_DECERR   = 2'b11
  } resp_e;

  typedef struct packed {
    src_e        src;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  function automatic src_e other_src(src_e s);
    return (s == SRC_DATA) ? SRC_INSTR : SRC_DATA;
  endfunction

endpackage

// File: rtl/ibex_avalon_arb_tag_fifo.sv
// In-order tag FIFO recording which port owns each outstanding Avalon command.
// Pushes when full and pops when empty are ignored, so the count never wraps.
module ibex_avalon_arb_tag_fifo
  import ibex_avalon_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  tag_t             push_tag_i,
  input  logic             pop_i,
  output tag_t             head_tag_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  tag_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign full_o     = (count_q == CNT_W'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign head_tag_o = mem_q[rd_ptr_q];
  assign do_push    = push_i & ~full_o;
  assign do_pop     = pop_i & ~empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Tag storage needs no reset: entries are only read while the count covers them.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_tag_i;
  end

endmodule

// File: rtl/ibex_avalon_arbiter.sv
// Arbitrates the Ibex instruction and data ports onto one Avalon-MM master.
// Define IBEX_AVALON_ARB_RR_EN for round-robin; otherwise data has fixed priority.
module ibex_avalon_arbiter
  import ibex_avalon_arb_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        instr_req_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  input  logic [31:0] instr_addr_i,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        avm_read_o,
  output logic        avm_write_o,
  output logic [31:0] avm_address_o,
  output logic [3:0]  avm_byteenable_o,
  output logic [31:0] avm_writedata_o,
  input  logic        avm_waitrequest_i,
  input  logic [31:0] avm_readdata_i,
  input  logic        avm_readdatavalid_i,
  input  logic        avm_writeresponsevalid_i,
  input  logic [1:0]  avm_response_i
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  arb_state_e       state_q, state_d;
  cmd_t             hold_q, hold_d;
  cmd_t             port_cmd, cmd;
  logic             active_q;
  logic             issue, accept, cmd_room;
  src_e             sel_src;
  tag_t             push_tag, head_tag;
  logic             tag_full, tag_empty;
  logic [CNT_W-1:0] tag_count;
  logic             resp_valid, deliver, resp_err;
  logic [31:0]      resp_rdata;

`ifdef IBEX_AVALON_ARB_RR_EN
  src_e prio_q, prio_d;

  always_comb begin
    sel_src = SRC_DATA;
    if (instr_req_i && data_req_i) sel_src = prio_q;
    else if (instr_req_i)          sel_src = SRC_INSTR;
  end

  always_comb begin
    prio_d = prio_q;
    if (accept && instr_req_i && data_req_i) prio_d = other_src(cmd.src);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) prio_q <= SRC_DATA;
    else         prio_q <= prio_d;
  end
`else
  assign sel_src = data_req_i ? SRC_DATA : SRC_INSTR;
`endif

  always_comb begin
    port_cmd     = '0;
    port_cmd.src = sel_src;
    if (sel_src == SRC_DATA) begin
      port_cmd.we    = data_we_i;
      port_cmd.be    = data_be_i;
      port_cmd.addr  = data_addr_i;
      port_cmd.wdata = data_wdata_i;
    end else begin
      port_cmd.be    = 4'hF;
      port_cmd.addr  = instr_addr_i;
    end
  end

  assign cmd_room = ~tag_full & (tag_count < CNT_W'(MAX_OUTSTANDING));

  // A stalled command is replayed from hold_q so the bus never sees it change.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cmd     = port_cmd;
    issue   = 1'b0;
    case (state_q)
      ARB:  issue = active_q & (instr_req_i | data_req_i) & cmd_room;
      HOLD: begin
        cmd   = hold_q;
        issue = 1'b1;
      end
    endcase
    accept = issue & ~avm_waitrequest_i;
    if (issue && avm_waitrequest_i) begin
      state_d = HOLD;
      hold_d  = cmd;
    end else if (accept) begin
      state_d = ARB;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ARB;
      hold_q   <= '0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      active_q <= 1'b1;
    end
  end

  assign avm_read_o       = issue & ~cmd.we;
  assign avm_write_o      = issue & cmd.we;
  assign avm_address_o    = issue ? cmd.addr  : '0;
  assign avm_byteenable_o = issue ? cmd.be    : '0;
  assign avm_writedata_o  = issue ? cmd.wdata : '0;
  assign instr_gnt_o      = accept & (cmd.src == SRC_INSTR);
  assign data_gnt_o       = accept & (cmd.src == SRC_DATA);

  assign push_tag.src      = cmd.src;
  assign push_tag.is_write = cmd.we;
  assign resp_valid        = avm_readdatavalid_i | avm_writeresponsevalid_i;

  ibex_avalon_arb_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push_i     (accept),
    .push_tag_i (push_tag),
    .pop_i      (resp_valid),
    .head_tag_o (head_tag),
    .full_o     (tag_full),
    .empty_o    (tag_empty),
    .count_o    (tag_count)
  );

  // A response whose kind disagrees with the head tag is still delivered, flagged as an error.
  assign deliver    = resp_valid & ~tag_empty;
  assign resp_err   = (avm_response_i != RESP_OKAY)
                    | (avm_readdatavalid_i & head_tag.is_write)
                    | (avm_writeresponsevalid_i & ~head_tag.is_write);
  assign resp_rdata = (avm_readdatavalid_i && !head_tag.is_write) ? avm_readdata_i : '0;

  assign instr_rvalid_o = deliver & (head_tag.src == SRC_INSTR);
  assign data_rvalid_o  = deliver & (head_tag.src == SRC_DATA);
  assign instr_rdata_o  = instr_rvalid_o ? resp_rdata : '0;
  assign data_rdata_o   = data_rvalid_o  ? resp_rdata : '0;
  assign instr_err_o    = instr_rvalid_o & resp_err;
  assign data_err_o     = data_rvalid_o  & resp_err;

endmodule

// File: tb/tb_ibex_avalon_arbiter.sv
// Randomised bench for ibex_avalon_arbiter: a transaction-level model (outstanding
// tag queue, pending-command record, priority flag) predicts every output each cycle.
module tb_ibex_avalon_arbiter;

  localparam int MAXO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        instr_req = 0, data_req = 0, data_we = 0;
  logic [31:0] instr_addr = 0, data_addr = 0, data_wdata = 0;
  logic [3:0]  data_be = 0;
  logic        avm_wait = 0, avm_rdv = 0, avm_wrv = 0;
  logic [31:0] avm_rdata = 0;
  logic [1:0]  avm_resp = 0;

  logic        instr_gnt, instr_rvalid, instr_err, data_gnt, data_rvalid, data_err;
  logic [31:0] instr_rdata, data_rdata, avm_address, avm_writedata;
  logic        avm_read, avm_write;
  logic [3:0]  avm_be;

  always #5 clk = ~clk;

  ibex_avalon_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .instr_req_i(instr_req), .instr_gnt_o(instr_gnt), .instr_rvalid_o(instr_rvalid),
    .instr_addr_i(instr_addr), .instr_rdata_o(instr_rdata), .instr_err_o(instr_err),
    .data_req_i(data_req), .data_gnt_o(data_gnt), .data_rvalid_o(data_rvalid),
    .data_we_i(data_we), .data_be_i(data_be), .data_addr_i(data_addr),
    .data_wdata_i(data_wdata), .data_rdata_o(data_rdata), .data_err_o(data_err),
    .avm_read_o(avm_read), .avm_write_o(avm_write), .avm_address_o(avm_address),
    .avm_byteenable_o(avm_be), .avm_writedata_o(avm_writedata),
    .avm_waitrequest_i(avm_wait), .avm_readdata_i(avm_rdata),
    .avm_readdatavalid_i(avm_rdv), .avm_writeresponsevalid_i(avm_wrv),
    .avm_response_i(avm_resp)
  );

  int    n_cmp = 0, n_bad = 0;
  string phase = "init";

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s.%s got=%h exp=%h", phase, tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { bit src; bit wr; } mtag_t;   // src: 1 = data port
  mtag_t       mq[$];
  bit          pend_v, pend_src, pend_we, prio_data;
  logic [3:0]  pend_be;
  logic [31:0] pend_addr, pend_wdata;
  bit          exp_gnt_i, exp_gnt_d;
  bit          obs_gnt_i, obs_gnt_d, obs_write, obs_rv_i, obs_rv_d, obs_err_i, obs_err_d;
  logic [31:0] obs_rdata_i;

  task automatic model_reset();
    mq.delete();
    pend_v = 0; pend_src = 0; pend_we = 0; pend_be = 0; pend_addr = 0; pend_wdata = 0;
    prio_data = 1;
    exp_gnt_i = 0; exp_gnt_d = 0;
  endtask

  task automatic eval_and_check();
    bit iss = 0, src = 0, we = 0, acc, rv_i = 0, rv_d = 0, er = 0;
    logic [3:0]  be = 0;
    logic [31:0] addr = 0, wd = 0, rd = 0;
    mtag_t h;
    if (pend_v) begin
      iss = 1; src = pend_src; we = pend_we; be = pend_be; addr = pend_addr; wd = pend_wdata;
    end else if ((instr_req || data_req) && mq.size() < MAXO) begin
      iss = 1;
`ifdef IBEX_AVALON_ARB_RR_EN
      src = (instr_req && data_req) ? prio_data : data_req;
`else
      src = data_req;
`endif
      if (src) begin we = data_we; be = data_be; addr = data_addr; wd = data_wdata; end
      else begin we = 0; be = 4'hF; addr = instr_addr; wd = 0; end
    end
    acc = iss && !avm_wait;
    exp_gnt_i = acc && !src;
    exp_gnt_d = acc && src;
    if ((avm_rdv || avm_wrv) && mq.size() > 0) begin
      h = mq.pop_front();
      rv_i = !h.src; rv_d = h.src;
      er = (avm_resp != 2'b00) || (avm_rdv && h.wr) || (avm_wrv && !h.wr);
      rd = (avm_rdv && !h.wr) ? avm_rdata : 32'h0;
    end
    check_val("avm_read",  avm_read,      iss && !we);
    check_val("avm_write", avm_write,     iss && we);
    check_val("avm_addr",  avm_address,   addr);
    check_val("avm_be",    avm_be,        be);
    check_val("avm_wdata", avm_writedata, wd);
    check_val("instr_gnt", instr_gnt,     exp_gnt_i);
    check_val("data_gnt",  data_gnt,      exp_gnt_d);
    check_val("instr_rv",  instr_rvalid,  rv_i);
    check_val("data_rv",   data_rvalid,   rv_d);
    check_val("instr_rd",  instr_rdata,   rv_i ? rd : 32'h0);
    check_val("data_rd",   data_rdata,    rv_d ? rd : 32'h0);
    check_val("instr_err", instr_err,     rv_i && er);
    check_val("data_err",  data_err,      rv_d && er);
    obs_gnt_i = instr_gnt; obs_gnt_d = data_gnt; obs_write = avm_write;
    obs_rv_i = instr_rvalid; obs_rv_d = data_rvalid; obs_err_i = instr_err;
    obs_err_d = data_err; obs_rdata_i = instr_rdata;
    if (acc) mq.push_back('{src, we});
    pend_v = iss && avm_wait;
    pend_src = src; pend_we = we; pend_be = be; pend_addr = addr; pend_wdata = wd;
    if (acc && instr_req && data_req) prio_data = !src;
  endtask

  task automatic tick();
    @(negedge clk);
    eval_and_check();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    instr_req = 0; data_req = 0; data_we = 0; instr_addr = 0; data_addr = 0;
    data_wdata = 0; data_be = 0; avm_wait = 0; avm_rdv = 0; avm_wrv = 0;
    avm_rdata = 0; avm_resp = 0;
  endtask

  task automatic check_idle_outputs();
    check_val("rst_ignt", instr_gnt, 0);    check_val("rst_dgnt", data_gnt, 0);
    check_val("rst_irv", instr_rvalid, 0);  check_val("rst_drv", data_rvalid, 0);
    check_val("rst_ierr", instr_err, 0);    check_val("rst_derr", data_err, 0);
    check_val("rst_ird", instr_rdata, 0);   check_val("rst_drd", data_rdata, 0);
    check_val("rst_read", avm_read, 0);     check_val("rst_write", avm_write, 0);
    check_val("rst_addr", avm_address, 0);  check_val("rst_be", avm_be, 0);
    check_val("rst_wdata", avm_writedata, 0);
  endtask

  // Reset is applied with busy inputs so the outputs are proven forced low.
  task automatic do_reset(input int cycles);
    rst_n = 0;
    instr_req = 1; instr_addr = 32'h40; data_req = 1; data_we = 1; data_be = 4'hF;
    data_addr = 32'h80; data_wdata = 32'h1234_5678; avm_rdv = 1; avm_rdata = 32'hCAFE_F00D;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check_idle_outputs();
      @(posedge clk);
      #1;
    end
    clear_inputs();
    rst_n = 1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_random();
    if (!instr_req || exp_gnt_i) begin
      instr_req  = ($urandom_range(0, 2) != 0);
      instr_addr = $urandom & 32'hFFFF_FFFC;
    end
    if (!data_req || exp_gnt_d) begin
      data_req   = ($urandom_range(0, 1) != 0);
      data_we    = $urandom_range(0, 1) != 0;
      data_be    = 4'($urandom_range(1, 15));
      data_addr  = $urandom & 32'hFFFF_FFFC;
      data_wdata = $urandom;
    end
    avm_wait = ($urandom_range(0, 3) == 0);
    avm_rdv = 0; avm_wrv = 0; avm_resp = 2'b00; avm_rdata = $urandom;
    if (mq.size() > 0 && $urandom_range(0, 2) == 0) begin
      if ($urandom_range(0, 15) == 0) begin avm_rdv = mq[0].wr; avm_wrv = !mq[0].wr; end
      else begin avm_rdv = !mq[0].wr; avm_wrv = mq[0].wr; end
      if ($urandom_range(0, 3) == 0) avm_resp = 2'($urandom_range(1, 3));
    end else if (mq.size() == 0 && $urandom_range(0, 19) == 0) begin
      avm_rdv = 1;
    end
  endtask

  initial begin
    int gnt_cycle, gnts;
    #2;
    phase = "reset";
    do_reset(3);

    // Both ports requesting back-to-back with a zero-latency slave.
    phase = "both_req";
    instr_req = 1; data_req = 1; data_be = 4'hF;
    for (int k = 0; k < 8; k++) begin
      instr_addr = 32'h1000 + 32'(k * 4); data_addr = 32'h3000 + 32'(k * 4);
      avm_rdv = (mq.size() > 0); avm_rdata = 32'(k);
      tick();
      check_val("acc", obs_gnt_i | obs_gnt_d, 1);
`ifdef IBEX_AVALON_ARB_RR_EN
      check_val("order_d", obs_gnt_d, (k % 2) == 0);
`else
      check_val("order_d", obs_gnt_d, 1);
`endif
    end
    instr_req = 0; data_req = 0; avm_rdv = 1;
    tick();
    avm_rdv = 0;
    tick();

    phase = "instr_wait";
    do_reset(1);
    instr_req = 1; instr_addr = 32'h100; gnt_cycle = 0;
    for (int k = 1; k <= 3; k++) begin
      avm_wait = (k < 3);
      tick();
      if (obs_gnt_i && gnt_cycle == 0) gnt_cycle = k;
    end
    check_val("gnt_cycle", gnt_cycle, 3);
    clear_inputs();
    tick();
    avm_rdv = 1; avm_rdata = 32'hDEAD_BEEF;
    tick();
    check_val("rvalid", obs_rv_i, 1);
    check_val("rdata", obs_rdata_i, 32'hDEAD_BEEF);
    check_val("err", obs_err_i, 0);
    clear_inputs();

    phase = "data_write";
    data_req = 1; data_we = 1; data_be = 4'b0011; data_addr = 32'h2000; data_wdata = 32'h5A5A_0F0F;
    tick();
    gnts = int'(obs_write);
    clear_inputs();
    avm_wrv = 1; avm_resp = 2'b10;
    tick();
    gnts += int'(obs_write);
    check_val("writes", gnts, 1);
    check_val("rvalid", obs_rv_d, 1);
    check_val("err", obs_err_d, 1);
    clear_inputs();

    phase = "full";
    instr_req = 1; gnts = 0;
    for (int k = 0; k < 6; k++) begin
      instr_addr = 32'h500 + 32'(gnts * 4);
      tick();
      gnts += int'(obs_gnt_i);
    end
    check_val("accepted", gnts, MAXO);
    avm_rdv = 1; avm_rdata = 32'h11;
    tick();
    check_val("gnt_on_pop", obs_gnt_i, 0);
    check_val("pop_rv", obs_rv_i, 1);
    avm_rdv = 0;
    tick();
    check_val("gnt_after", obs_gnt_i, 1);
    instr_req = 0; avm_rdv = 1;
    repeat (MAXO) tick();
    avm_rdv = 0;

    phase = "reset_mid";
    instr_req = 1; instr_addr = 32'h700;
    tick();
    instr_req = 0; data_req = 1; data_addr = 32'h704; data_be = 4'hF;
    tick();
    do_reset(2);
    avm_rdv = 1; avm_rdata = 32'h7777_7777;
    tick();
    check_val("rv_i", obs_rv_i, 0);
    check_val("rv_d", obs_rv_d, 0);
    clear_inputs();

    phase = "random";
    for (int k = 0; k < 3000; k++) begin
      drive_random();
      tick();
      if (k == 1500) begin
        do_reset(1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
